// File: rtl/shifter_pkg.sv
// Shared opcode and FSM state definitions for the sequential shifter.
package shifter_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_LSL  = 3'b010,
        OP_LSR  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSV  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // True for the opcodes that move bits (and may take several cycles).
    function automatic logic is_shift_op(input op_e op);
        logic res;
        res = 1'b0;
        case (op)
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single combinational shift/rotate step of k bits (k may be 0) with carry-out.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned KW    = 2
) (
    input  logic [WIDTH-1:0] d_i,
    input  op_e              op_i,
    input  logic [KW-1:0]    k_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] d_o_c,
    output logic             carry_o_c
);

    logic        [WIDTH:0]   lsl_w;
    logic        [WIDTH:0]   lsr_w;
    logic signed [WIDTH:0]   asr_w;
    logic        [WIDTH-1:0] rol_w;
    logic        [WIDTH-1:0] ror_w;
    int unsigned             k_int;

    // Extra guard bit on each shift captures the last bit pushed out.
    always_comb begin
        k_int = 32'(k_i);
        lsl_w = {1'b0, d_i} << k_i;
        lsr_w = {d_i, 1'b0} >> k_i;
        asr_w = $signed({d_i, 1'b0}) >>> k_i;
        rol_w = (d_i << k_int) | (d_i >> (WIDTH - k_int));
        ror_w = (d_i >> k_int) | (d_i << (WIDTH - k_int));

        d_o_c     = d_i;
        carry_o_c = carry_i;
        if (k_i != '0) begin
            case (op_i)
                OP_LSL: begin
                    d_o_c     = lsl_w[WIDTH-1:0];
                    carry_o_c = lsl_w[WIDTH];
                end
                OP_LSR: begin
                    d_o_c     = lsr_w[WIDTH:1];
                    carry_o_c = lsr_w[0];
                end
                OP_ASR: begin
                    d_o_c     = asr_w[WIDTH:1];
                    carry_o_c = asr_w[0];
                end
                OP_ROL: begin
                    d_o_c     = rol_w;
                    carry_o_c = rol_w[0];
                end
                OP_ROR: begin
                    d_o_c     = ror_w;
                    carry_o_c = ror_w[WIDTH-1];
                end
                default: begin
                    d_o_c     = d_i;
                    carry_o_c = carry_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle shift/rotate register: up to MAX_STEP bits per cycle with
// valid/ready command intake, busy/done status and carry-out.
module shifter_seq
    import shifter_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned MAX_STEP = 3,
    localparam int unsigned SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int unsigned KW = $clog2(MAX_STEP + 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    op_e              cmd_op_c;
    op_e              step_op_c;
    logic [SHW-1:0]   step_src_c;
    logic [KW-1:0]    step_k_c;
    logic [SHW-1:0]   rem_after_c;
    logic [WIDTH-1:0] step_res_c;
    logic             step_carry_c;
    logic             accept_c;

    // Step operand select: in flight use the latched op/remaining, else the new command.
    always_comb begin
        cmd_op_c    = op_e'(op);
        step_src_c  = (state_q == ST_SHIFT) ? rem_q : shamt;
        step_op_c   = (state_q == ST_SHIFT) ? op_q  : cmd_op_c;
        step_k_c    = (step_src_c > SHW'(MAX_STEP)) ? KW'(MAX_STEP) : KW'(step_src_c);
        rem_after_c = step_src_c - SHW'(step_k_c);
        accept_c    = cmd_valid & ~busy_q & ~clr;
    end

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .d_i       (d_q),
        .op_i      (step_op_c),
        .k_i       (step_k_c),
        .carry_i   (carry_q),
        .d_o_c     (step_res_c),
        .carry_o_c (step_carry_c)
    );

    // Next-state, datapath and status; clr overrides everything.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        d_d     = d_q;
        carry_d = carry_q;
        done_d  = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            d_d     = '0;
            carry_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        done_d = 1'b1;
                        if (cmd_op_c == OP_LOAD) begin
                            d_d = d_in;
                        end else if (is_shift_op(cmd_op_c) && (shamt != '0)) begin
                            // First step executes at the accepting edge.
                            d_d     = step_res_c;
                            carry_d = step_carry_c;
                            rem_d   = rem_after_c;
                            if (rem_after_c != '0) begin
                                state_d = ST_SHIFT;
                                op_d    = cmd_op_c;
                                done_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    d_d     = step_res_c;
                    carry_d = step_carry_c;
                    rem_d   = rem_after_c;
                    if (rem_after_c == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_SHIFT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            rem_q   <= '0;
            d_q     <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            d_q     <= d_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d_out     = d_q;
    assign carry     = carry_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = ~busy_q;

endmodule
